seg_scroll_buf: RTL

- Message buffer and scroll engine that feeds the 8-digit seven-segment scan stage.
- Holds up to MSG_LEN active-low segment patterns and presents an 8-digit window on a 64-bit bus.
- Steps the window left or right once per STEP_DIV clocks.
- The downstream scanner selects digit i from seg_bus on scan index i (digit 0 = rightmost position).

---
 rtl/seg_scroll_buf_if.sv | 40 ++++
 rtl/seg_scroll_buf.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg_scroll_buf_if.sv
// Bundle of write, control and display signals between a host and seg_scroll_buf.
// The blink input exists only when SEG_SCROLL_BLINK_EN is defined.
interface seg_scroll_buf_if #(
    parameter int MSG_LEN = 16
);
    localparam int AW = $clog2(MSG_LEN);

    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [7:0]    wr_data_i;
    logic [AW:0]   len_i;
    logic          run_i;
    logic          dir_i;
`ifdef SEG_SCROLL_BLINK_EN
    logic          blink_i;
`endif
    logic [63:0]   seg_bus_o;
    logic          step_pulse_o;
    logic          wrap_o;

`ifdef SEG_SCROLL_BLINK_EN
    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, len_i, run_i, dir_i, blink_i,
        input  seg_bus_o, step_pulse_o, wrap_o
    );
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, len_i, run_i, dir_i, blink_i,
        output seg_bus_o, step_pulse_o, wrap_o
    );
`else
    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, len_i, run_i, dir_i,
        input  seg_bus_o, step_pulse_o, wrap_o
    );
    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, len_i, run_i, dir_i,
        output seg_bus_o, step_pulse_o, wrap_o
    );
`endif
endinterface

// File: rtl/seg_scroll_buf.sv
// Message buffer and scroll engine presenting an 8-digit window to the segment scanner.
// Define SEG_SCROLL_BLINK_EN to add blink gating of the window on alternate steps.
module seg_scroll_buf #(
    parameter int MSG_LEN  = 16,
    parameter int STEP_DIV = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    seg_scroll_buf_if.slave bus
);
    localparam int AW   = $clog2(MSG_LEN);
    localparam int LW   = AW + 1;
    localparam int CW   = $clog2(STEP_DIV);
    localparam int NSUB = MSG_LEN / 8 + 1;
    localparam logic [LW-1:0] MAX_LEN  = LW'(MSG_LEN);
    localparam logic [LW-1:0] DIGITS   = LW'(8);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    logic [7:0]    buf_q [MSG_LEN];
    logic [AW-1:0] offset_q, offset_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   seg_q, seg_d;
    logic [63:0]   window;
    logic [LW-1:0] effLen;
    logic [LW-1:0] idx;
    logic          longMsg;
    logic          step;
    logic          step_q;
    logic          wrap_q, wrap_d;

    assign effLen  = (bus.len_i > MAX_LEN) ? MAX_LEN : bus.len_i;
    assign longMsg = effLen > DIGITS;
    assign step    = bus.run_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.run_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // An out-of-range offset after a length change is cleared before any step is honoured.
    always_comb begin
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (!longMsg || ({1'b0, offset_q} >= effLen)) begin
            offset_d = '0;
        end else if (step) begin
            if (!bus.dir_i) begin
                if ({1'b0, offset_q} == effLen - LW'(1)) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + AW'(1);
                end
            end else begin
                if (offset_q == '0) begin
                    offset_d = AW'(effLen - LW'(1));
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q - AW'(1);
                end
            end
        end
    end

    // Bounded repeated subtraction gives (offset + i) mod L without a divider.
    always_comb begin
        window = '1;
        idx    = '0;
        for (int i = 0; i < 8; i++) begin
            idx = {1'b0, offset_q} + LW'(i);
            for (int k = 0; k < NSUB; k++) begin
                if (idx >= effLen) begin
                    idx = idx - effLen;
                end
            end
            if (longMsg) begin
                window[8*i +: 8] = buf_q[idx[AW-1:0]];
            end else if (LW'(i) < effLen) begin
                window[8*i +: 8] = buf_q[AW'(i)];
            end
        end
    end

`ifdef SEG_SCROLL_BLINK_EN
    logic phase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= 1'b0;
        end else if (step) begin
            phase_q <= ~phase_q;
        end
    end

    assign seg_d = (bus.blink_i && phase_q) ? '1 : window;
`else
    assign seg_d = window;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            offset_q <= '0;
            seg_q    <= '1;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            seg_q    <= seg_d;
            step_q   <= step;
            wrap_q   <= wrap_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MSG_LEN; k++) begin
                buf_q[k] <= 8'hFF;
            end
        end else if (bus.wr_en_i) begin
            buf_q[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    assign bus.seg_bus_o    = seg_q;
    assign bus.step_pulse_o = step_q;
    assign bus.wrap_o       = wrap_q;
endmodule
